// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one shift-add multiplier among NUM_REQ requesters.
// Optional build macro MUL_EARLY_TERM_EN ends CALC as soon as the remaining multiplier bits are zero.
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_product,
    input  logic                     resp_ready,
    output logic                     busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    grant_id;
    logic               grant_found;
    logic [2*WIDTH-1:0] grant_a;
    logic [2*WIDTH-1:0] grant_b;
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] b_sh;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               calc_last;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        grant_a = {{WIDTH{1'b0}}, req_a[int'(grant_id)*WIDTH +: WIDTH]};
        grant_b = {{WIDTH{1'b0}}, req_b[int'(grant_id)*WIDTH +: WIDTH]};
    end

    // The handshake completes in the grant cycle; held off while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (n_rst && (state == IDLE) && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        acc_next = acc + (a_sh[0] ? b_sh : '0);
`ifdef MUL_EARLY_TERM_EN
        calc_last = (cnt == CNT_W'(WIDTH - 1)) || ((a_sh >> 1) == '0);
`else
        calc_last = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            a_sh         <= '0;
            b_sh         <= '0;
            acc          <= '0;
            cnt          <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= '0;
            resp_product <= '0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_sh   <= grant_a;
                        b_sh   <= grant_b;
                        acc    <= '0;
                        cnt    <= '0;
                        cur_id <= grant_id;
                        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                        busy   <= 1'b1;
`ifdef MUL_EARLY_TERM_EN
                        if (grant_a == '0) begin
                            state        <= DONE;
                            resp_valid   <= 1'b1;
                            resp_id      <= grant_id;
                            resp_product <= '0;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    acc  <= acc_next;
                    b_sh <= b_sh << 1;
                    a_sh <= a_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (calc_last) begin
                        state        <= DONE;
                        resp_valid   <= 1'b1;
                        resp_id      <= cur_id;
                        resp_product <= acc_next;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed and random traffic against a transaction-level model of the arbiter.
// Honours MUL_EARLY_TERM_EN when computing expected latency.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     n_rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     resp_valid;
    logic [ID_W-1:0]          resp_id;
    logic [2*WIDTH-1:0]       resp_product;
    logic                     resp_ready;
    logic                     busy;

    always #5 clk = ~clk;

    mul_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .resp_valid(resp_valid),
        .resp_id(resp_id),
        .resp_product(resp_product),
        .resp_ready(resp_ready),
        .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    // Transaction-level model: idle / computing (cycles left) / result waiting.
    bit                 m_idle = 1'b1;
    bit                 m_resp = 1'b0;
    int                 m_wait = 0;
    int                 m_ptr  = 0;
    int                 m_id   = 0;
    logic [2*WIDTH-1:0] m_prod = '0;
    int                 last_grant = -1;

    logic [NUM_REQ-1:0]       pend = '0;
    logic [NUM_REQ*WIDTH-1:0] op_a = '0;
    logic [NUM_REQ*WIDTH-1:0] op_b = '0;
    logic                     rdy  = 1'b1;

    logic [ID_W-1:0]    seen_id[$];
    logic [2*WIDTH-1:0] seen_prod[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int calc_cycles(input logic [WIDTH-1:0] a);
        int n;
        n = WIDTH;
`ifdef MUL_EARLY_TERM_EN
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) n = i + 1;
        end
`endif
        return n;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ*WIDTH-1:0] a,
                                 input logic [NUM_REQ*WIDTH-1:0] b, input logic ready);
        int                 g;
        int                 idx;
        logic [NUM_REQ-1:0] exp_ready;
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        @(negedge clk);
        req_valid  = valid;
        req_a      = a;
        req_b      = b;
        resp_ready = ready;
        #1;
        g = -1;
        if (m_idle) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("busy", 32'(busy), 32'(!m_idle));
        checkOutput("resp_valid", 32'(resp_valid), 32'(m_resp));
        if (m_resp) begin
            checkOutput("resp_id", 32'(resp_id), 32'(m_id));
            checkOutput("resp_product", 32'(resp_product), 32'(m_prod));
        end
        last_grant = g;
        if (g >= 0) begin
            ea     = {{WIDTH{1'b0}}, a[g*WIDTH +: WIDTH]};
            eb     = {{WIDTH{1'b0}}, b[g*WIDTH +: WIDTH]};
            m_id   = g;
            m_prod = ea * eb;
            m_ptr  = (g + 1) % NUM_REQ;
            m_idle = 1'b0;
            m_wait = calc_cycles(a[g*WIDTH +: WIDTH]);
            m_resp = (m_wait == 0);
        end else if (!m_idle && !m_resp) begin
            m_wait--;
            if (m_wait == 0) m_resp = 1'b1;
        end else if (m_resp && ready) begin
            seen_id.push_back(resp_id);
            seen_prod.push_back(resp_product);
            m_resp = 1'b0;
            m_idle = 1'b1;
        end
    endtask

    task automatic tick();
        applyStimulus(pend, op_a, op_b, rdy);
        if (last_grant >= 0) pend[last_grant] = 1'b0;
    endtask

    task automatic drain(input int limit);
        for (int c = 0; c < limit && !(m_idle && pend == '0); c++) tick();
        if (!(m_idle && pend == '0)) checkOutput("drain_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic checkSeen(input string tag, input int i, input int exp_id, input int exp_prod);
        checkOutput({tag, "_id"}, (i < seen_id.size()) ? 32'(seen_id[i]) : 32'hDEAD, 32'(exp_id));
        checkOutput({tag, "_prod"}, (i < seen_prod.size()) ? 32'(seen_prod[i]) : 32'hDEAD, 32'(exp_prod));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        checkOutput({tag, "_resp_product"}, 32'(resp_product), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_rst      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #2;
        n_rst     = 1'b0;
        req_valid = '1;
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        req_valid = '0;
        n_rst     = 1'b1;

        $display("[TB] all four requesters at once");
        seen_id.delete();
        seen_prod.delete();
        op_a = {4'h4, 4'h3, 4'h2, 4'h1};
        op_b = {4'hF, 4'hF, 4'hF, 4'hF};
        pend = 4'hF;
        rdy  = 1'b1;
        drain(60);
        checkOutput("all4_count", 32'(seen_id.size()), 32'd4);
        checkSeen("all4_0", 0, 0, 8'h0F);
        checkSeen("all4_1", 1, 1, 8'h1E);
        checkSeen("all4_2", 2, 2, 8'h2D);
        checkSeen("all4_3", 3, 3, 8'h3C);

        $display("[TB] round-robin wrap after req3");
        seen_id.delete();
        seen_prod.delete();
        op_a = {4'h0, 4'h5, 4'h0, 4'h3};
        op_b = {4'h0, 4'h6, 4'h0, 4'h7};
        pend = 4'b0101;
        drain(40);
        checkSeen("wrap_0", 0, 0, 8'h15);
        checkSeen("wrap_1", 1, 2, 8'h1E);

        $display("[TB] single request");
        seen_id.delete();
        seen_prod.delete();
        op_a = {4'h0, 4'h0, 4'h0, 4'hB};
        op_b = {4'h0, 4'h0, 4'h0, 4'hD};
        pend = 4'b0001;
        drain(20);
        checkSeen("single", 0, 0, 8'h8F);

        $display("[TB] back-pressure and boundary operands");
        seen_id.delete();
        seen_prod.delete();
        op_a = {4'h0, 4'h0, 4'h0, 4'hF};
        op_b = {4'h0, 4'h0, 4'h9, 4'hF};
        pend = 4'b0001;
        rdy  = 1'b0;
        for (int c = 0; c < 20 && !m_resp; c++) tick();
        pend = 4'b0010;
        repeat (10) tick();
        rdy = 1'b1;
        drain(20);
        checkSeen("bp_ff", 0, 0, 8'hE1);
        checkSeen("bp_zero", 1, 1, 8'h00);

        $display("[TB] reset during CALC");
        seen_id.delete();
        seen_prod.delete();
        op_a = {4'h0, 4'h7, 4'h0, 4'h0};
        op_b = {4'h0, 4'h5, 4'h0, 4'h0};
        pend = 4'b0100;
        repeat (3) tick();
        @(negedge clk);
        req_valid = 4'b1001;
        n_rst     = 1'b0;
        #1;
        checkResetOutputs("midreset");
        m_idle = 1'b1;
        m_resp = 1'b0;
        m_ptr  = 0;
        pend   = '0;
        @(negedge clk);
        req_valid = '0;
        n_rst     = 1'b1;
        repeat (8) tick();
        checkOutput("midreset_no_resp", 32'(seen_id.size()), 32'd0);
        op_a = {4'h9, 4'h0, 4'h0, 4'h6};
        op_b = {4'h3, 4'h0, 4'h0, 4'h7};
        pend = 4'b1001;
        drain(40);
        checkSeen("after_reset_0", 0, 0, 8'h2A);
        checkSeen("after_reset_1", 1, 3, 8'h1B);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i]                = 1'b1;
                    op_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                    op_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end else if (pend[i] && ($urandom_range(0, 15) == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        rdy = 1'b1;
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one iterative shift-add multiplier engine among NUM_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready request channel, and all requesters share one valid/ready response channel tagged with the requester ID.
- Sits between the operand producers and the result consumer in the multiply subsystem, and serialises all multiply traffic through a single engine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand width in bits. The product is 2*WIDTH bits.
- ID_W, 2, width of the requester index. Must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  input  1  clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  multipliers, flattened; requester i uses [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  multiplicands, flattened the same way.
- resp_valid  output  1  result available.
- resp_id  output  ID_W  index of the requester that owns the result.
- resp_product  output  2*WIDTH  unsigned product a*b.
- resp_ready  input  1  consumer accepts the result.
- busy  output  1  high when state != IDLE.

Behaviour:
Reset (asynchronous, n_rst=0):
- state=IDLE; rr_ptr=0.
- Operand, accumulator and counter registers = 0.
- resp_valid=0, resp_id=0, resp_product=0, busy=0, req_ready=0.
- Reset may occur mid-operation. Any in-flight op is dropped and no response is issued.

State machine (IDLE, CALC, DONE):
- IDLE:
  - If any req_valid is high, the grant goes to the first requester with valid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant]=1 combinationally in that cycle, so the handshake completes in that same cycle.
  - On that edge: latch a, b zero-extended to 2*WIDTH, and grant ID; clear the accumulator to 0; set cnt=0; rr_ptr <= grant+1 (mod NUM_REQ); go to CALC.
  - If no req_valid is high, stay in IDLE.
- CALC, one bit per cycle:
  - If a_sh[0]=1: acc <= acc + b_sh (2*WIDTH bits; no overflow is possible).
  - b_sh <= b_sh<<1; a_sh <= a_sh>>1; cnt <= cnt+1.
  - When cnt==WIDTH-1, go to DONE.
  - All req_ready=0.
- DONE:
  - resp_valid=1; resp_product=acc; resp_id=latched ID.
  - Outputs stay stable until resp_ready=1; the transfer happens on that edge, then go to IDLE.
  - Back-pressure is unlimited.
  - No new grant is issued in the same cycle as the response transfer. The next grant happens in IDLE at the earliest one cycle later.

Timing and handshake rules:
- Latency: accept at edge T gives resp_valid=1 after edge T+WIDTH. This is WIDTH+1 cycles for the full-length case.
- Throughput: one op per WIDTH+2 cycles with resp_ready held at 1.
- A requester may drop req_valid before it is granted; no grant results for it.
- Granted operands are sampled only on the accept edge, so later changes do not matter.
- Simultaneous requests from all NUM_REQ requesters are served in rotating order. Starvation-free: each valid requester waits at most NUM_REQ-1 ops.
- Operand 0 on either side gives product 0 through the full CALC length, unless the optional feature below is enabled.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - CALC moves to DONE after the current cycle when the next a_sh value (a_sh>>1) is 0, or when cnt==WIDTH-1, whichever comes first.
  - If the latched a==0, the design skips CALC and goes from IDLE directly to DONE with product 0. Latency is then 1 cycle.
  - Latency for nonzero a = (index of the MSB set in a)+1 CALC cycles, plus the accept cycle.
- Not defined: CALC always runs exactly WIDTH cycles.
- Results are identical in both builds; only timing differs.

Test Plan:
- Single request: req0 a=4'hB, b=4'hD, resp_ready=1 → resp_valid after 5 cycles, resp_product=8'h8F, resp_id=0, busy low 1 cycle later.
- All four requesters valid at once, each with distinct operands (a=i+1, b=4'hF) → responses in order id 0,1,2,3 with products 0F,1E,2D,3C. Each req_ready pulses exactly once.
- Back-pressure: resp_ready=0 for 10 cycles during DONE → resp_valid, resp_id and resp_product held constant. req_valid from another requester is not granted until 1 cycle after resp_ready=1.
- Round-robin wrap: after a grant to req3, req0 and req2 are valid → req0 is granted first.
- Boundary operands: a=4'hF, b=4'hF → 8'hE1. a=0, b=4'h9 → 8'h00. With MUL_EARLY_TERM_EN: latency 1 for a=0, and 2 CALC cycles for a=4'h2.
- Reset mid-CALC: assert n_rst low at cnt=2 → all outputs immediately 0, no resp_valid afterwards. The next request is granted to req0 with a correct product.
